// File: rtl/laser_spot_tracker_pkg.sv
// Shared definitions for the laser spot tracker.
//   PIXEL_SIZE     : width of a packed pixel {R,B,G}
//   *_HI / *_LO    : channel bit positions inside a pixel word
//   state_t        : 2-bit tracker FSM encoding
package laser_spot_tracker_pkg;

  localparam int PIXEL_SIZE = 24;

  localparam int R_HI = 23;
  localparam int R_LO = 16;
  localparam int B_HI = 15;
  localparam int B_LO = 8;
  localparam int G_HI = 7;
  localparam int G_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_RUN     = 2'd2,
    ST_PUBLISH = 2'd3
  } state_t;

endpackage

// File: rtl/laser_spot_tracker_pixel_brightness_threshold.sv
// Combinational brightness classifier for one pixel.
//   i_data       : pixel {R[23:16],B[15:8],G[7:0]}
//   i_threshold  : brightness threshold
//   o_bright     : (R+G+B)>>2 strictly greater than threshold
//   o_sum_mean   : (R+G+B)>>2, the value that is compared
module pixel_brightness_threshold
  import laser_spot_tracker_pkg::*;
(
  input  logic [PIXEL_SIZE-1:0] i_data,
  input  logic [7:0]            i_threshold,
  output logic                  o_bright,
  output logic [7:0]            o_sum_mean
);

  logic [9:0] w_sum;

  // Sum is 10 bits wide so three full-scale channels never overflow.
  assign w_sum      = {2'b00, i_data[R_HI:R_LO]} + {2'b00, i_data[G_HI:G_LO]} +
                      {2'b00, i_data[B_HI:B_LO]};
  assign o_sum_mean = w_sum[9:2];
  assign o_bright   = (o_sum_mean > i_threshold);

endmodule

// File: rtl/laser_spot_tracker.sv
// Per-frame laser spot locator. Finds the longest horizontal run of bright
// pixels (at least MIN_RUN long) in each frame and publishes its centre once
// per frame, one cycle after the eof pixel.
//   clk, reset_n            : pixel clock, synchronous active-low reset
//   en                      : pixel valid (no backpressure: a pixel is consumed
//                             on every rising edge where en is high; sof/eol/eof
//                             and data are ignored while en is low)
//   sof, eol, eof           : frame/row markers, qualified by en
//   threshold               : brightness threshold
//   pixel_col, pixel_row    : coordinates of data
//   data                    : pixel {R,B,G}
//   laser_xy, laser_found   : last published spot and whether it was found
//   laser_valid             : one-cycle pulse when laser_xy/laser_found update
//   debug                   : brightness overlay (only with LASER_SPOT_DEBUG_EN)
//   fsm_state               : current tracker state, for observation
// Build option: define LASER_SPOT_DEBUG_EN to enable the debug overlay flops;
// otherwise debug is tied to zero.
module laser_spot_tracker
  import laser_spot_tracker_pkg::*;
#(
  parameter int COORD_W = 16,
  parameter int RUN_W   = 16,
  parameter int MIN_RUN = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  sof,
  input  logic                  eol,
  input  logic                  eof,
  input  logic [7:0]            threshold,
  input  logic [COORD_W-1:0]    pixel_col,
  input  logic [COORD_W-1:0]    pixel_row,
  input  logic [PIXEL_SIZE-1:0] data,
  output logic [2*COORD_W-1:0]  laser_xy,
  output logic                  laser_found,
  output logic                  laser_valid,
  output logic [PIXEL_SIZE-1:0] debug,
  output logic [1:0]            fsm_state
);

  state_t             r_state, w_state_nxt, w_cur;
  logic [COORD_W-1:0] r_run_col, r_run_row, w_run_col_nxt, w_run_row_nxt;
  logic [RUN_W-1:0]   r_run_len, w_run_len_nxt, w_len_inc;
  logic [COORD_W-1:0] r_best_x, r_best_y, w_best_x_nxt, w_best_y_nxt;
  logic [RUN_W-1:0]   r_best_len, w_best_len_nxt;
  logic [2*COORD_W-1:0] r_laser_xy;
  logic               r_found, r_valid;
  logic               w_close, w_publish;
  logic [RUN_W-1:0]   w_close_len, w_half;
  logic [COORD_W-1:0] w_close_col, w_close_row;
  logic               w_bright;
  logic [7:0]         w_sum_mean;

  pixel_brightness_threshold u_bright (
    .i_data      (data),
    .i_threshold (threshold),
    .o_bright    (w_bright),
    .o_sum_mean  (w_sum_mean)
  );

  assign w_len_inc = (r_run_len == {RUN_W{1'b1}}) ? r_run_len : r_run_len + RUN_W'(1);
  assign w_half    = (w_close_len - RUN_W'(1)) >> 1;

  always_comb begin
    w_state_nxt    = r_state;
    w_cur          = r_state;
    w_run_col_nxt  = r_run_col;
    w_run_row_nxt  = r_run_row;
    w_run_len_nxt  = r_run_len;
    w_best_x_nxt   = r_best_x;
    w_best_y_nxt   = r_best_y;
    w_best_len_nxt = r_best_len;
    w_close        = 1'b0;
    w_close_len    = r_run_len;
    w_close_col    = r_run_col;
    w_close_row    = r_run_row;
    w_publish      = 1'b0;

    // Best run is forgotten once published, so an eof arriving without a
    // fresh sof reports not-found.
    if (r_state == ST_PUBLISH) begin
      w_state_nxt    = ST_IDLE;
      w_best_len_nxt = '0;
    end

    if (en) begin
      if (sof) begin
        w_cur          = ST_SCAN;
        w_state_nxt    = ST_SCAN;
        w_best_len_nxt = '0;
        w_run_len_nxt  = '0;
      end

      case (w_cur)
        ST_SCAN: begin
          w_state_nxt = ST_SCAN;
          if (w_bright) begin
            w_run_col_nxt = pixel_col;
            w_run_row_nxt = pixel_row;
            w_run_len_nxt = RUN_W'(1);
            if (eol || eof) begin
              // single-pixel run ending at row end closes immediately
              w_close     = 1'b1;
              w_close_len = RUN_W'(1);
              w_close_col = pixel_col;
              w_close_row = pixel_row;
            end else begin
              w_state_nxt = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_bright) begin
            w_run_len_nxt = w_len_inc;
            if (eol || eof) begin
              // bright pixel at row end is part of the run it closes
              w_close     = 1'b1;
              w_close_len = w_len_inc;
              w_state_nxt = ST_SCAN;
            end
          end else begin
            w_close     = 1'b1;
            w_close_len = r_run_len;
            w_state_nxt = ST_SCAN;
          end
        end
        default: ;
      endcase

      if (eof) begin
        w_state_nxt = ST_PUBLISH;
        w_publish   = 1'b1;
      end
    end

    // Strictly longer replaces: on a tie the earlier run is kept.
    if (w_close && (w_close_len >= RUN_W'(MIN_RUN)) && (w_close_len > w_best_len_nxt)) begin
      w_best_len_nxt = w_close_len;
      w_best_x_nxt   = w_close_col + COORD_W'(w_half);
      w_best_y_nxt   = w_close_row;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_run_col  <= '0;
      r_run_row  <= '0;
      r_run_len  <= '0;
      r_best_x   <= '0;
      r_best_y   <= '0;
      r_best_len <= '0;
      r_laser_xy <= '0;
      r_found    <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_run_col  <= w_run_col_nxt;
      r_run_row  <= w_run_row_nxt;
      r_run_len  <= w_run_len_nxt;
      r_best_x   <= w_best_x_nxt;
      r_best_y   <= w_best_y_nxt;
      r_best_len <= w_best_len_nxt;
      r_valid    <= w_publish;
      // Publish uses the best values including a run closed by the eof pixel.
      if (w_publish) begin
        r_found <= (w_best_len_nxt != '0);
        if (w_best_len_nxt != '0) begin
          r_laser_xy <= {w_best_x_nxt, w_best_y_nxt};
        end
      end
    end
  end

`ifdef LASER_SPOT_DEBUG_EN
  logic [PIXEL_SIZE-1:0] r_debug;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_debug <= '0;
    end else begin
      r_debug <= (en && w_bright) ? {3{w_sum_mean}} : '0;
    end
  end

  assign debug = r_debug;
`else
  logic w_unused_sum;

  assign w_unused_sum = ^w_sum_mean;
  assign debug        = '0;
`endif

  assign laser_xy    = r_laser_xy;
  assign laser_found = r_found;
  assign laser_valid = r_valid;
  assign fsm_state   = r_state;

endmodule

// File: tb/tb_laser_spot_tracker.sv
// Directed bench for laser_spot_tracker: frames are built from a bright-pixel
// map, expected publishes are queued by the stimulus side and checked by an
// independent monitor whenever laser_valid is seen.
module tb_laser_spot_tracker;

  logic        clk;
  logic        reset_n;
  logic        en, sof, eol, eof;
  logic [7:0]  threshold;
  logic [15:0] pixel_col, pixel_row;
  logic [23:0] data;
  logic [31:0] laser_xy;
  logic        laser_found, laser_valid;
  logic [23:0] debug;
  logic [1:0]  fsm_state;

  laser_spot_tracker #(.COORD_W(16), .RUN_W(16), .MIN_RUN(5)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .sof         (sof),
    .eol         (eol),
    .eof         (eof),
    .threshold   (threshold),
    .pixel_col   (pixel_col),
    .pixel_row   (pixel_row),
    .data        (data),
    .laser_xy    (laser_xy),
    .laser_found (laser_found),
    .laser_valid (laser_valid),
    .debug       (debug),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int          exp_cyc_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          last_cyc;
  logic        bmap [0:7][0:63];

  // Bright is mean 65 > 0x40; dark is mean 64, exactly on the threshold.
  localparam logic [23:0] BRIGHT_PIX = 24'h575757;
  localparam logic [23:0] DARK_PIX   = 24'h575557;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [32:0] mon_e;
  int          mon_c;
  always @(negedge clk) begin
    if (reset_n && laser_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_publish: got found=%b xy=%h expected no pulse", laser_found, laser_xy);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("publish", {31'd0, laser_found, laser_xy}, {31'd0, mon_e});
        check("publish_cycle", 64'(cyc), 64'(mon_c));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle_cycle();
    // en low with all markers asserted: must be ignored entirely
    en = 1'b0; sof = 1'b1; eol = 1'b1; eof = 1'b1; data = BRIGHT_PIX;
    @(posedge clk); #1;
    sof = 1'b0; eol = 1'b0; eof = 1'b0;
  endtask

  task automatic pix(input int c, input int r, input logic br, input logic s,
                     input logic el, input logic ef);
    en = 1'b1; sof = s; eol = el; eof = ef;
    pixel_col = 16'(c); pixel_row = 16'(r);
    data = br ? BRIGHT_PIX : DARK_PIX;
    @(posedge clk); #1;
    last_cyc = cyc;
    en = 1'b0; sof = 1'b0; eol = 1'b0; eof = 1'b0;
  endtask

  task automatic clear_map();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 64; c++) bmap[r][c] = 1'b0;
  endtask

  task automatic set_run(input int r, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) bmap[r][c] = 1'b1;
  endtask

  task automatic frame(input int w, input int h, input bit do_eof, input bit gaps,
                       input logic [32:0] exp);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (gaps && ($urandom_range(0, 1) == 1)) idle_cycle();
        pix(c, r, bmap[r][c], (r == 0 && c == 0), (c == w - 1),
            do_eof && (r == h - 1) && (c == w - 1));
      end
    end
    if (do_eof) begin
      exp_q.push_back(exp);
      exp_cyc_q.push_back(last_cyc);
      check("state_publish", 64'(fsm_state), 64'd3);
      idle_cycle();
      idle_cycle();
      check("state_idle", 64'(fsm_state), 64'd0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_xy"},    64'(laser_xy), 64'd0);
    check({tag, "_found"}, 64'(laser_found), 64'd0);
    check({tag, "_valid"}, 64'(laser_valid), 64'd0);
    check({tag, "_state"}, 64'(fsm_state), 64'd0);
    check({tag, "_debug"}, 64'(debug), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; en = 1'b0; sof = 1'b0; eol = 1'b0; eof = 1'b0;
    threshold = 8'h40; pixel_col = '0; pixel_row = '0; data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset_n = 1'b1;
    idle_cycle();
    check_reset_values("post_reset");

    // run of 6 at row 2 cols 3..8 -> centre 5
    clear_map(); set_run(2, 3, 8);
    frame(16, 4, 1, 0, {1'b1, 16'd5, 16'd2});

    // only a run of 4 -> not found, xy held
    clear_map(); set_run(1, 2, 5);
    frame(16, 4, 1, 0, {1'b0, 16'd5, 16'd2});

    // two runs of 6, second ends on eol/eof; tie keeps the first
    clear_map(); set_run(1, 0, 5); set_run(3, 10, 15);
    frame(16, 4, 1, 0, {1'b1, 16'd2, 16'd1});

    // bright across a row boundary splits into two runs of 4
    clear_map(); set_run(0, 60, 63); set_run(1, 0, 3);
    frame(64, 2, 1, 0, {1'b0, 16'd2, 16'd1});

    // abandoned frame with a run of 9, then sof restarts; run of 7 with en gaps
    clear_map(); set_run(1, 0, 8);
    frame(16, 2, 0, 0, 33'd0);
    clear_map(); set_run(2, 4, 10);
    frame(16, 4, 1, 1, {1'b1, 16'd7, 16'd2});

    // exactly MIN_RUN qualifies
    clear_map(); set_run(0, 1, 5);
    frame(16, 2, 1, 0, {1'b1, 16'd3, 16'd0});

    // longer later run replaces earlier one
    clear_map(); set_run(0, 1, 5); set_run(1, 8, 14);
    frame(16, 2, 1, 0, {1'b1, 16'd11, 16'd1});

    // reset in the middle of a run: no publish, outputs cleared
    for (int c = 0; c < 6; c++) pix(c, 0, 1'b1, (c == 0), 1'b0, 1'b0);
    reset_n = 1'b0; en = 1'b1; data = BRIGHT_PIX; eof = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    en = 1'b0; eof = 1'b0;
    check_reset_values("midrun_reset");
    reset_n = 1'b1;
    idle_cycle();

    // run of 8 at row 5 col 20 -> centre 23
    clear_map(); set_run(5, 20, 27);
    frame(32, 6, 1, 0, {1'b1, 16'd23, 16'd5});

    // eof without sof publishes not-found, xy held
    pix(0, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_q.push_back({1'b0, 16'd23, 16'd5});
    exp_cyc_q.push_back(last_cyc);
    repeat (5) idle_cycle();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
